// File: rtl/data_ram_dp.sv
// Simple-dual-port data RAM with one write port and a registered read port.
// A sequential sweep zeroes the array after reset or on request, with busy held high meanwhile.
module data_ram_dp #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH          = 256,
    parameter int CLEAR_ON_RESET = 1,
    parameter int BYPASS         = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    typedef enum logic {RUN, CLEAR} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  collide;

    assign busy        = (state == CLEAR);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign wr_ok       = wr_en && !busy && wr_in_range;
    assign rd_ok       = rd_en && !busy;
    assign collide     = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (clear_req) state_next = CLEAR;
            CLEAR:   if (clr_addr == LAST_ADDR) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + ADDR_WIDTH'(1);
        end
    end

    // Storage has no reset; the sweep is the only thing that zeroes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (busy) begin
                mem[clr_addr] <= '0;
            end else if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                if (!rd_in_range) begin
                    rd_data <= '0;
                end else if (collide) begin
                    rd_data <= wr_data;
                end else begin
                    rd_data <= mem[rd_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_dp.sv
// Bench for data_ram_dp: three instances (write-first, read-first, DEPTH=200) share one stimulus
// stream; a behavioural model pushes expected read data to per-instance scoreboard queues.
module tb_data_ram_dp;

    logic       clock;
    logic       reset;
    logic       clear_req;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_addr;

    logic       dut_busy     [3];
    logic [7:0] dut_rd_data  [3];
    logic       dut_rd_valid [3];

    int n_checks = 0;
    int n_errors = 0;

    int         m_depth  [3] = '{256, 256, 200};
    bit         m_bypass [3] = '{1'b1, 1'b0, 1'b1};
    int         m_cnt    [3];
    logic       m_valid  [3];
    logic [7:0] m_last   [3];
    logic [7:0] m_mem    [3][256];

    logic [7:0] sb_q0 [$];
    logic [7:0] sb_q1 [$];
    logic [7:0] sb_q2 [$];

    data_ram_dp u_dut_wf (
        .clock(clock), .reset(reset), .clear_req(clear_req), .busy(dut_busy[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dut_rd_data[0]), .rd_valid(dut_rd_valid[0])
    );

    data_ram_dp #(.BYPASS(0)) u_dut_rf (
        .clock(clock), .reset(reset), .clear_req(clear_req), .busy(dut_busy[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dut_rd_data[1]), .rd_valid(dut_rd_valid[1])
    );

    data_ram_dp #(.DEPTH(200)) u_dut_d200 (
        .clock(clock), .reset(reset), .clear_req(clear_req), .busy(dut_busy[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dut_rd_data[2]), .rd_valid(dut_rd_valid[2])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic sb_push(input int i, input logic [7:0] v);
        case (i)
            0:       sb_q0.push_back(v);
            1:       sb_q1.push_back(v);
            default: sb_q2.push_back(v);
        endcase
    endtask

    task automatic sb_pop(input int i, output logic [7:0] v, output bit ok);
        ok = 1'b1;
        v  = '0;
        case (i)
            0:       if (sb_q0.size() > 0) v = sb_q0.pop_front(); else ok = 1'b0;
            1:       if (sb_q1.size() > 0) v = sb_q1.pop_front(); else ok = 1'b0;
            default: if (sb_q2.size() > 0) v = sb_q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // Reference model: follows the documented behaviour, updated on each active edge.
    initial begin
        logic [7:0] v;
        forever begin
            @(posedge clock or negedge reset);
            for (int i = 0; i < 3; i++) begin
                if (!reset) begin
                    m_cnt[i]   = m_depth[i];
                    m_valid[i] = 1'b0;
                    m_last[i]  = 8'h00;
                end else if (m_cnt[i] > 0) begin
                    m_cnt[i]--;
                    m_valid[i] = 1'b0;
                    if (m_cnt[i] == 0) begin
                        for (int j = 0; j < 256; j++) m_mem[i][j] = 8'h00;
                    end
                end else begin
                    m_valid[i] = rd_en;
                    if (rd_en) begin
                        if (int'(rd_addr) >= m_depth[i])
                            v = 8'h00;
                        else if (m_bypass[i] && wr_en && wr_addr == rd_addr)
                            v = wr_data;
                        else
                            v = m_mem[i][rd_addr];
                        m_last[i] = v;
                        sb_push(i, v);
                    end
                    if (wr_en && int'(wr_addr) < m_depth[i]) m_mem[i][wr_addr] = wr_data;
                    if (clear_req) m_cnt[i] = m_depth[i];
                end
            end
        end
    end

    initial begin
        logic [7:0] v;
        bit ok;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                check_output($sformatf("busy[%0d]", i), 32'(dut_busy[i]), 32'(m_cnt[i] > 0));
                check_output($sformatf("rd_valid[%0d]", i), 32'(dut_rd_valid[i]), 32'(m_valid[i]));
                check_output($sformatf("rd_data_hold[%0d]", i), 32'(dut_rd_data[i]), 32'(m_last[i]));
                if (dut_rd_valid[i]) begin
                    sb_pop(i, v, ok);
                    check_output($sformatf("sb_nonempty[%0d]", i), 32'(ok), 32'd1);
                    if (ok) check_output($sformatf("sb_data[%0d]", i), 32'(dut_rd_data[i]), 32'(v));
                end
            end
        end
    end

    task automatic apply_stimulus(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                                  input logic re, input logic [7:0] ra, input logic cr);
        @(negedge clock);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_en     = re;
        rd_addr   = ra;
        clear_req = cr;
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (dut_busy[0] && n < 1000) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while ((dut_busy[0] || dut_busy[1] || dut_busy[2]) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) check_output("ready_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        clear_req = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 8'h00;
        wr_data   = 8'h00;
        rd_en     = 1'b0;
        rd_addr   = 8'h00;

        // Sweep after reset, then every address must read back zero.
        repeat (3) @(negedge clock);
        check_output("reset_rd_data", 32'(dut_rd_data[0]), 32'h00);
        check_output("reset_busy", 32'(dut_busy[0]), 32'd1);
        reset = 1'b1;
        measure_busy(n);
        check_output("sweep_len_after_reset", 32'(n), 32'd256);
        wait_ready();
        for (int a = 0; a < 256; a++) apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'(a), 1'b0);
        idle(1);

        // Write then read on the next cycle; the idle cycle must hold the data.
        apply_stimulus(1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b0);
        idle(1);
        check_output("t2_rd_data", 32'(dut_rd_data[0]), 32'hA5);
        check_output("t2_rd_valid", 32'(dut_rd_valid[0]), 32'd1);
        idle(1);
        check_output("t2_idle_valid", 32'(dut_rd_valid[0]), 32'd0);
        check_output("t2_idle_hold", 32'(dut_rd_data[0]), 32'hA5);

        // Same-address collision: write-first versus read-first.
        apply_stimulus(1'b1, 8'h20, 8'h11, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b1, 8'h20, 8'h5A, 1'b1, 8'h20, 1'b0);
        idle(1);
        check_output("t3_write_first", 32'(dut_rd_data[0]), 32'h5A);
        check_output("t3_read_first", 32'(dut_rd_data[1]), 32'h11);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 1'b0);
        idle(1);
        check_output("t3_read_first_later", 32'(dut_rd_data[1]), 32'h5A);

        // Clear request with a simultaneous write; traffic during the sweep is ignored.
        for (int a = 0; a < 4; a++) apply_stimulus(1'b1, 8'(a), 8'hFF, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b1, 8'h02, 8'h33, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 100; k++)
            apply_stimulus(1'b1, 8'(k % 4), 8'h44, 1'b1, 8'(k % 4), 1'b1);
        idle(1);
        wait_ready();
        for (int a = 0; a < 4; a++) apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'(a), 1'b0);
        idle(1);
        check_output("t4_addr3_cleared", 32'(dut_rd_data[0]), 32'h00);

        // Reset in the middle of a sweep restarts a full sweep.
        apply_stimulus(1'b1, 8'h40, 8'h9C, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h40, 1'b0);
        idle(1);
        check_output("t5_pre_data", 32'(dut_rd_data[0]), 32'h9C);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        idle(101);
        #1 reset = 1'b0;
        #1;
        check_output("t5_reset_rd_data", 32'(dut_rd_data[0]), 32'h00);
        check_output("t5_reset_rd_valid", 32'(dut_rd_valid[0]), 32'd0);
        idle(2);
        reset = 1'b1;
        measure_busy(n);
        check_output("t5_sweep_len", 32'(n), 32'd256);
        wait_ready();

        // Out-of-range on the DEPTH=200 instance: dropped write, zero read, no aliasing.
        apply_stimulus(1'b1, 8'd50, 8'h3C, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b1, 8'd250, 8'h77, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'd250, 1'b0);
        idle(1);
        check_output("t6_oor_data", 32'(dut_rd_data[2]), 32'h00);
        check_output("t6_oor_valid", 32'(dut_rd_valid[2]), 32'd1);
        check_output("t6_full_depth_data", 32'(dut_rd_data[0]), 32'h77);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'd50, 1'b0);
        idle(1);
        check_output("t6_no_alias", 32'(dut_rd_data[2]), 32'h3C);

        // Mixed random traffic over a small address set plus out-of-range addresses.
        for (int k = 0; k < 80; k++) begin
            logic [7:0] wa, ra;
            wa = ($urandom_range(0, 3) == 0) ? 8'(200 + $urandom_range(0, 55)) : 8'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 7));
            apply_stimulus(1'($urandom_range(0, 1)), wa, 8'($urandom_range(0, 255)),
                           1'($urandom_range(0, 1)), ra, 1'b0);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
